mem_stage_hs: RTL
=================

Name: mem_stage_hs

Overview:
Parametrised successor to the pipeline memory-access stage. It accepts one instruction per handshake and drives a request/acknowledge data-memory port with any latency, instead of a zero-latency fake memory. It generates byte enables, aligns and sign/zero-extends load data, and flags misaligned, illegal and timed-out accesses. It sits between execute and write-back, with valid/ready flow control on both sides.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; byte lanes NB = XLEN/8
TIMEOUT, 64, cycles to wait for mem_ack before faulting; 0 disables the timeout

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
ir_in  in  32  instruction
a_in  in  XLEN  effective address / ALU result
b_in  in  XLEN  store data
pc_in  in  XLEN  program counter
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
ir_out  out  32  registered instruction
rd_out  out  XLEN  extended load data; 0 for non-loads
a_out  out  XLEN  registered a_in
pc_out  out  XLEN  registered pc_in
fault_out  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal funct3
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = store
mem_addr  out  XLEN  a_in with low log2(NB) bits cleared
mem_wdata  out  XLEN  lane-shifted store data
mem_be  out  NB  byte enables
mem_ack  in  1  single-cycle completion pulse
mem_rdata  in  XLEN  read data, valid with mem_ack

Behaviour:
- Reset: state IDLE. All outputs 0 except in_ready = 1. mem_req drops asynchronously. An ack arriving after reset is ignored.
- States:
  - IDLE: in_ready = 1. On in_valid, capture ir/a/b/pc.
    - Opcode LOAD (0000011) or STORE (0100011), legal and aligned: go to ACCESS.
    - Otherwise: go to HOLD.
  - ACCESS: mem_req, mem_we, mem_addr, mem_wdata and mem_be are registered and held stable until mem_ack.
    - On ack: loads capture extended data into rd_out; go to HOLD.
    - On timeout expiry: drop mem_req, set fault 10, rd_out = 0, go to HOLD.
  - HOLD: out_valid = 1 and all outputs held until out_ready.
    - out_ready with in_valid: capture the next instruction in the same cycle (back-to-back).
    - out_ready without in_valid: go to IDLE.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational from out_ready.
- Latency:
  - Non-memory instruction: out_valid in the cycle after acceptance.
  - Memory instruction: mem_req first high in the cycle after acceptance. out_valid in the cycle after mem_ack is sampled. Ack in the first req cycle gives 2-cycle total latency.
- funct3 = ir[14:12].
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; plus 011 LD and 110 LWU when XLEN=64.
  - Legal stores: 000 SB, 001 SH, 010 SW; plus 011 SD when XLEN=64.
  - Other funct3 values: fault 11, no request.
- Misalignment: size >1 byte with any address bit below log2(size) set gives fault 01, no request.
- Let off = a[log2(NB)-1:0].
  - Store: mem_be = ((1<<size)-1) << off; mem_wdata = b << 8*off.
  - Load: shift mem_rdata right by 8*off, truncate to size, then sign- or zero-extend to XLEN.
- Non-memory instructions: fault 00, rd_out = 0. Stores: rd_out = 0.
- Timeout counter clears on entry to ACCESS. Fault fires when count reaches TIMEOUT with no ack. An ack in the same cycle as expiry wins.
- mem_ack outside ACCESS is ignored.

Decomposition:
- Package mem_stage_pkg:
  - opcode constants OP_LOAD and OP_STORE
  - funct3 constants
  - fault codes FLT_NONE/MISAL/TIMEOUT/ILLEGAL
  - state enum IDLE/ACCESS/HOLD
  - a size-decode function mapping funct3 to byte count
- Sub-module mem_lane_align: purely combinational. Given funct3, offset, store data and read data, it produces mem_be, mem_wdata, extended load data, and the misaligned/illegal flags. It is parametrised by XLEN.

Test Plan:
1. XLEN=32, LW a=0x100, memory returns 0xDEADBEEF with ack 3 cycles after req -> mem_be=1111, mem_addr=0x100, rd_out=0xDEADBEEF, fault 00, out_valid 1 cycle after ack.
2. LB a=0x103, rdata=0x80FF_FF00 -> rd_out=0xFFFFFF80; same access with LBU -> rd_out=0x00000080.
3. SH a=0x102, b=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD0000; LH a=0x101 -> fault 01, mem_req never asserted.
4. TIMEOUT=4, LW with no ack -> mem_req drops after 4 cycles, fault 10, rd_out=0; a later stray ack has no effect.
5. Back-to-back: ADD then LW with out_ready held 1 -> in_ready high in HOLD, ADD retires with rd_out=0, LW issues next cycle; out_ready held 0 for 3 cycles -> outputs stable throughout.
6. rst pulsed while mem_req=1 -> mem_req=0 and out_valid=0 immediately, in_ready=1; ack in the next cycle is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants, types and helpers for the handshaked memory-access stage.
package mem_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_MISAL   = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  // Access size in bytes; the unsigned variants share the low two bits.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Upstream, downstream and data-memory handshake signals of the memory stage.
interface mem_stage_hs_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     ir_in;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic [XLEN-1:0] pc_in;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     ir_out;
  logic [XLEN-1:0] rd_out;
  logic [XLEN-1:0] a_out;
  logic [XLEN-1:0] pc_out;
  logic [1:0]      fault_out;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [NB-1:0]   mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  in_valid, ir_in, a_in, b_in, pc_in, out_ready, mem_ack, mem_rdata,
    output in_ready, out_valid, ir_out, rd_out, a_out, pc_out, fault_out,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output in_valid, ir_in, a_in, b_in, pc_in, out_ready, mem_ack, mem_rdata,
    input  in_ready, out_valid, ir_out, rd_out, a_out, pc_out, fault_out,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/data, load extraction and
// sign/zero extension, plus legality and alignment checks.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OW   = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [OW-1:0]   off,
  input  logic [XLEN-1:0] sdata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata,
  output logic            misal,
  output logic            illegal
);

  logic [3:0]      sz;
  logic [3:0]      sz_m1;
  logic [6:0]      nbits;
  logic [NB-1:0]   mask;
  logic [XLEN-1:0] sh;
  logic            fill;

  assign sz    = size_bytes(funct3);
  assign sz_m1 = sz - 4'd1;
  assign nbits = {sz, 3'b000};

  always_comb begin
    illegal = 1'b1;
    if (is_store) begin
      case (funct3)
        F3_B, F3_H, F3_W: illegal = 1'b0;
        F3_D:             illegal = (XLEN != 64);
        default:          illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal = 1'b0;
        F3_D, F3_WU:                    illegal = (XLEN != 64);
        default:                        illegal = 1'b1;
      endcase
    end
  end

  // Any offset bit below log2(size) set means the access straddles its natural boundary.
  assign misal = ((4'(off) & sz_m1) != 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_mask
      assign mask[gi] = (4'(gi) < sz);
    end
  endgenerate

  assign be    = mask << off;
  assign wdata = sdata << {off, 3'b000};
  assign sh    = rdata >> {off, 3'b000};

  always_comb begin
    case (funct3[1:0])
      2'b00:   fill = sh[7];
      2'b01:   fill = sh[15];
      2'b10:   fill = sh[31];
      default: fill = sh[XLEN-1];
    endcase
    if (funct3[2]) fill = 1'b0;
  end

  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_ext
      assign ldata[gi] = (7'(gi) < nbits) ? sh[gi] : fill;
    end
  endgenerate

endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline memory-access stage with valid/ready flow control on both sides and a
// request/acknowledge data-memory port of arbitrary latency, with timeout.
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_hs_if.slave  bus
);

  localparam int NB   = XLEN / 8;
  localparam int OW   = $clog2(NB);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t          state_reg;
  logic [31:0]     ir_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] rd_reg;
  logic [1:0]      fault_reg;
  logic            out_valid_reg;
  logic            mem_req_reg;
  logic            mem_we_reg;
  logic [XLEN-1:0] mem_addr_reg;
  logic [XLEN-1:0] mem_wdata_reg;
  logic [NB-1:0]   mem_be_reg;
  logic [CW-1:0]   cnt_reg;

  logic            accept;
  logic            in_is_load;
  logic            in_is_store;
  logic            sel_acc;
  logic            timeout_hit;
  logic [2:0]      al_f3;
  logic            al_store;
  logic [OW-1:0]   al_off;
  logic [NB-1:0]   al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ldata;
  logic            al_misal;
  logic            al_illegal;

  assign bus.in_ready  = (state_reg == IDLE) | ((state_reg == HOLD) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign in_is_load    = (bus.ir_in[6:0] == OP_LOAD);
  assign in_is_store   = (bus.ir_in[6:0] == OP_STORE);
  assign timeout_hit   = (TIMEOUT != 0) && (cnt_reg == CW'(TMAX));

  // One aligner serves both the accept decision and the load return path.
  assign sel_acc  = (state_reg == ACCESS);
  assign al_f3    = sel_acc ? ir_reg[14:12]  : bus.ir_in[14:12];
  assign al_store = sel_acc ? mem_we_reg     : in_is_store;
  assign al_off   = sel_acc ? a_reg[OW-1:0]  : bus.a_in[OW-1:0];

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .funct3   (al_f3),
    .is_store (al_store),
    .off      (al_off),
    .sdata    (bus.b_in),
    .rdata    (bus.mem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ldata    (al_ldata),
    .misal    (al_misal),
    .illegal  (al_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ir_reg        <= '0;
      a_reg         <= '0;
      pc_reg        <= '0;
      rd_reg        <= '0;
      fault_reg     <= FLT_NONE;
      out_valid_reg <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        ACCESS: begin
          if (bus.mem_ack) begin
            mem_req_reg   <= 1'b0;
            rd_reg        <= mem_we_reg ? '0 : al_ldata;
            fault_reg     <= FLT_NONE;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else if (timeout_hit) begin
            mem_req_reg   <= 1'b0;
            rd_reg        <= '0;
            fault_reg     <= FLT_TIMEOUT;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready && !bus.in_valid) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: ;
      endcase

      if (accept) begin
        ir_reg        <= bus.ir_in;
        a_reg         <= bus.a_in;
        pc_reg        <= bus.pc_in;
        rd_reg        <= '0;
        cnt_reg       <= '0;
        mem_we_reg    <= 1'b0;
        mem_addr_reg  <= '0;
        mem_wdata_reg <= '0;
        mem_be_reg    <= '0;
        mem_req_reg   <= 1'b0;
        out_valid_reg <= 1'b1;
        state_reg     <= HOLD;
        if ((in_is_load || in_is_store) && al_illegal) begin
          fault_reg <= FLT_ILLEGAL;
        end else if ((in_is_load || in_is_store) && al_misal) begin
          fault_reg <= FLT_MISAL;
        end else if (in_is_load || in_is_store) begin
          fault_reg     <= FLT_NONE;
          mem_req_reg   <= 1'b1;
          mem_we_reg    <= in_is_store;
          mem_addr_reg  <= {bus.a_in[XLEN-1:OW], OW'(0)};
          mem_wdata_reg <= in_is_store ? al_wdata : '0;
          mem_be_reg    <= al_be;
          out_valid_reg <= 1'b0;
          state_reg     <= ACCESS;
        end else begin
          fault_reg <= FLT_NONE;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.ir_out    = ir_reg;
  assign bus.rd_out    = rd_reg;
  assign bus.a_out     = a_reg;
  assign bus.pc_out    = pc_reg;
  assign bus.fault_out = fault_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_be    = mem_be_reg;

endmodule
